sync_fifo_mc: RTL

Multi-channel synchronous FIFO: NUM_CH independent FIFOs sharing one clock, one write port and one read port, with channel select on each port. It generalises the single-channel sync_fifo to channel-interleaved traffic (e.g. per-queue DMA buffering). Storage is one shared RAM partitioned into equal per-channel regions, with per-channel pointers, fill counts and flags.

---
 rtl/sync_fifo_mc_pkg.sv | 15 +
 rtl/sync_fifo_mc_if.sv | 32 +++
 rtl/sync_fifo_mc_ram.sv | 37 +++
 rtl/sync_fifo_mc.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_mc_pkg.sv
// Shared constants and helpers for the multi-channel FIFO.
package sync_fifo_mc_pkg;
  localparam int LA_OFF = 0;
  localparam int LA_ON  = 1;

  // Channel-select width; never zero even if a single channel is requested.
  function automatic int ch_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LSB of channel c inside the packed used-words bus.
  function automatic int uw_lsb(input int c, input int aw);
    return c * (aw + 1);
  endfunction
endpackage

// File: rtl/sync_fifo_mc_if.sv
// Write/read port, per-channel flags and error bits of sync_fifo_mc.
interface sync_fifo_mc_if
  import sync_fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 4
);
  localparam int CH_WIDTH = ch_bits(NUM_CH);

  logic [NUM_CH-1:0]                  sclr;
  logic                               wr_en;
  logic [CH_WIDTH-1:0]                wr_ch;
  logic [DATA_WIDTH-1:0]              data_in;
  logic                               rd_en;
  logic [CH_WIDTH-1:0]                rd_ch;
  logic [DATA_WIDTH-1:0]              data_out;
  logic                               rd_valid;
  logic [NUM_CH-1:0]                  empty, full, afull, aempty;
  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   uw;
  logic [NUM_CH-1:0]                  ovf, udf;
  logic                               err_clr;

  modport master (
    output sclr, wr_en, wr_ch, data_in, rd_en, rd_ch, err_clr,
    input  data_out, rd_valid, empty, full, afull, aempty, uw, ovf, udf
  );
  modport slave (
    input  sclr, wr_en, wr_ch, data_in, rd_en, rd_ch, err_clr,
    output data_out, rd_valid, empty, full, afull, aempty, uw, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_mc_ram.sv
// Simple dual-port RAM; registered read (LA_OFF) or async read (LA_ON).
module sync_fifo_mc_ram
  import sync_fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 8,
  parameter int LOOKAHEAD  = LA_OFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  generate
    if (LOOKAHEAD == LA_ON) begin : g_async
      logic unused_rd;
      assign unused_rd = &{1'b0, rst_n, re};
      assign rdata = mem[raddr];
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] q;
      // Output register holds its value between reads.
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  q <= '0;
        else if (re) q <= mem[raddr];
      assign rdata = q;
    end
  endgenerate
endmodule

// File: rtl/sync_fifo_mc.sv
// Multi-channel sync FIFO over one partitioned RAM.
// Define SYNC_FIFO_MC_ERR_EN to enable sticky ovf/udf reporting.
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int NUM_CH       = 4,
  parameter int AFULL_LEVEL  = 56,
  parameter int AEMPTY_LEVEL = 8,
  parameter int LOOKAHEAD    = LA_OFF
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_mc_if.slave bus
);
  localparam int CH_WIDTH = ch_bits(NUM_CH);
  localparam int CW       = ADDR_WIDTH + 1;

  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] wptr, rptr;
  logic [NUM_CH-1:0][CW-1:0]         cnt;
  logic [NUM_CH-1:0]                 empty_q, full_q, afull_q, aempty_q;
  logic [NUM_CH-1:0]                 ovf_v, udf_v;
  logic                              wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0]             rdata;

  assign wr_acc = bus.wr_en & ~full_q[bus.wr_ch]  & ~bus.sclr[bus.wr_ch];
  assign rd_acc = bus.rd_en & ~empty_q[bus.rd_ch] & ~bus.sclr[bus.rd_ch];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic                  wr_hit, rd_hit, w, r;
      logic [CW-1:0]         cnt_nxt, cq;
      logic [ADDR_WIDTH-1:0] wp, rp;
      logic                  e_q, f_q, af_q, ae_q;

      assign wr_hit  = (bus.wr_ch == CH_WIDTH'(c));
      assign rd_hit  = (bus.rd_ch == CH_WIDTH'(c));
      assign w       = wr_acc & wr_hit;
      assign r       = rd_acc & rd_hit;
      assign cnt_nxt = bus.sclr[c] ? '0 : cq + CW'(w) - CW'(r);

      // Flags are registered from the next-state count so they move with the access.
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          wp <= '0; rp <= '0; cq <= '0;
          e_q <= 1'b1; f_q <= 1'b0; af_q <= 1'b0; ae_q <= 1'b1;
        end else begin
          wp   <= bus.sclr[c] ? '0 : wp + ADDR_WIDTH'(w);
          rp   <= bus.sclr[c] ? '0 : rp + ADDR_WIDTH'(r);
          cq   <= cnt_nxt;
          e_q  <= (cnt_nxt == '0);
          f_q  <= cnt_nxt[ADDR_WIDTH];
          af_q <= (cnt_nxt >= CW'(AFULL_LEVEL));
          ae_q <= (cnt_nxt <= CW'(AEMPTY_LEVEL));
        end

      assign wptr[c]     = wp;
      assign rptr[c]     = rp;
      assign cnt[c]      = cq;
      assign empty_q[c]  = e_q;
      assign full_q[c]   = f_q;
      assign afull_q[c]  = af_q;
      assign aempty_q[c] = ae_q;
      assign bus.uw[uw_lsb(c, ADDR_WIDTH) +: CW] = cq;

`ifdef SYNC_FIFO_MC_ERR_EN
      logic ovf_q, udf_q;
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          ovf_q <= 1'b0; udf_q <= 1'b0;
        end else if (bus.err_clr) begin
          ovf_q <= 1'b0; udf_q <= 1'b0;
        end else begin
          if (bus.wr_en & wr_hit & f_q & ~bus.sclr[c]) ovf_q <= 1'b1;
          if (bus.rd_en & rd_hit & e_q & ~bus.sclr[c]) udf_q <= 1'b1;
        end
      assign ovf_v[c] = ovf_q;
      assign udf_v[c] = udf_q;
`else
      assign ovf_v[c] = 1'b0;
      assign udf_v[c] = 1'b0;
`endif
    end
  endgenerate

`ifndef SYNC_FIFO_MC_ERR_EN
  logic unused_err;
  assign unused_err = bus.err_clr;
`endif

  assign bus.empty  = empty_q;
  assign bus.full   = full_q;
  assign bus.afull  = afull_q;
  assign bus.aempty = aempty_q;
  assign bus.ovf    = ovf_v;
  assign bus.udf    = udf_v;

  sync_fifo_mc_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (CH_WIDTH + ADDR_WIDTH),
    .LOOKAHEAD  (LOOKAHEAD)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_acc),
    .waddr ({bus.wr_ch, wptr[bus.wr_ch]}),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr ({bus.rd_ch, rptr[bus.rd_ch]}),
    .rdata (rdata)
  );

  assign bus.data_out = rdata;

  generate
    if (LOOKAHEAD == LA_ON) begin : g_la
      assign bus.rd_valid = ~empty_q[bus.rd_ch];
    end else begin : g_reg
      logic vld_q;
      always_ff @(posedge clk or negedge rst)
        if (!rst) vld_q <= 1'b0;
        else      vld_q <= rd_acc;
      assign bus.rd_valid = vld_q;
    end
  endgenerate
endmodule
